// File: rtl/xvga_pkg.sv
// xvga_pkg: shared counter widths, the raster timing record, standard modes and
// the timing-total / legality helpers used by xvga_timing.
package xvga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    logic [10:0] h_active;
    logic [10:0] h_fp;
    logic [10:0] h_sync;
    logic [10:0] h_bp;
    logic [9:0]  v_active;
    logic [9:0]  v_fp;
    logic [9:0]  v_sync;
    logic [9:0]  v_bp;
  } xvga_timing_t;

  localparam xvga_timing_t XVGA_640x480 = '{
    h_active: 11'd640,  h_fp: 11'd16, h_sync: 11'd96,  h_bp: 11'd48,
    v_active: 10'd480,  v_fp: 10'd10, v_sync: 10'd2,   v_bp: 10'd33
  };

  localparam xvga_timing_t XVGA_800x600 = '{
    h_active: 11'd800,  h_fp: 11'd40, h_sync: 11'd128, h_bp: 11'd88,
    v_active: 10'd600,  v_fp: 10'd1,  v_sync: 10'd4,   v_bp: 10'd23
  };

  localparam xvga_timing_t XVGA_1024x768 = '{
    h_active: 11'd1024, h_fp: 11'd24, h_sync: 11'd136, h_bp: 11'd160,
    v_active: 10'd768,  v_fp: 10'd3,  v_sync: 10'd6,   v_bp: 10'd29
  };

  // Totals are widened so that oversized offers can be detected rather than wrap.
  function automatic logic [12:0] h_total(xvga_timing_t t);
    return 13'(t.h_active) + 13'(t.h_fp) + 13'(t.h_sync) + 13'(t.h_bp);
  endfunction

  function automatic logic [11:0] v_total(xvga_timing_t t);
    return 12'(t.v_active) + 12'(t.v_fp) + 12'(t.v_sync) + 12'(t.v_bp);
  endfunction

  function automatic logic timing_ok(xvga_timing_t t);
    logic fields_set;
    fields_set = (t.h_active != '0) && (t.h_fp != '0) && (t.h_sync != '0) &&
                 (t.h_bp != '0) && (t.v_active != '0) && (t.v_fp != '0) &&
                 (t.v_sync != '0) && (t.v_bp != '0);
    return fields_set && (h_total(t) <= 13'd2048) && (v_total(t) <= 12'd1024);
  endfunction

endpackage

// File: rtl/xvga_timing_if.sv
// xvga_timing_if: timing-reconfiguration handshake between a mode controller
// (master) and the raster generator (slave).
interface xvga_timing_if;
  import xvga_pkg::*;

  logic         cfg_valid_in;
  logic         cfg_ready_out;
  xvga_timing_t cfg_in;
  logic         cfg_err_out;

  modport master (
    output cfg_valid_in,
    output cfg_in,
    input  cfg_ready_out,
    input  cfg_err_out
  );

  modport slave (
    input  cfg_valid_in,
    input  cfg_in,
    output cfg_ready_out,
    output cfg_err_out
  );

endinterface

// File: rtl/xvga_delay_line.sv
// xvga_delay_line: fixed-depth register delay with synchronous active-low reset
// to a given value; depth 0 degenerates to a wire.
module xvga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst_n;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/xvga_timing.sv
// xvga_timing: VGA raster generator (counters, sync/blank decode, strobes, frame count).
// Define XVGA_RUNTIME_CFG_EN to add the pending/active timing registers and handshake.
module xvga_timing
  import xvga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int          PIPE_DELAY = 0
) (
  input  logic                vclock_in,
  input  logic                rst_n_in,
  input  logic                enable_in,
  xvga_timing_if.slave        cfg,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                blank_out,
  output logic                line_start_out,
  output logic                frame_start_out,
  output logic [15:0]         frame_count_out
);

  localparam xvga_timing_t PARAM_TIMING = '{
    h_active: 11'(H_ACTIVE), h_fp: 11'(H_FP), h_sync: 11'(H_SYNC), h_bp: 11'(H_BP),
    v_active: 10'(V_ACTIVE), v_fp: 10'(V_FP), v_sync: 10'(V_SYNC), v_bp: 10'(V_BP)
  };

  // Returns {hsync active, vsync active, blank} for a raster position.
  function automatic logic [2:0] decode(xvga_timing_t t, logic [HCOUNT_W-1:0] h,
                                        logic [VCOUNT_W-1:0] v);
    logic [12:0] hs_lo, hs_hi;
    logic [11:0] vs_lo, vs_hi;
    logic        hs, vs, bl;
    hs_lo = 13'(t.h_active) + 13'(t.h_fp);
    hs_hi = hs_lo + 13'(t.h_sync);
    vs_lo = 12'(t.v_active) + 12'(t.v_fp);
    vs_hi = vs_lo + 12'(t.v_sync);
    hs    = (13'(h) >= hs_lo) && (13'(h) < hs_hi);
    vs    = (12'(v) >= vs_lo) && (12'(v) < vs_hi);
    bl    = (h >= t.h_active) || (v >= t.v_active);
    return {hs, vs, bl};
  endfunction

  xvga_timing_t          cur;
  logic [12:0]           ht;
  logic [11:0]           vt;
  logic [HCOUNT_W-1:0]   hcount, h_next;
  logic [VCOUNT_W-1:0]   vcount, v_next;
  logic [15:0]           frame_count;
  logic                  h_last, v_last, wrap;
  logic [2:0]            dec_next;
  logic                  hsync_p0, vsync_p0, blank_p0, line_start_p0, frame_start_p0;

  assign ht     = h_total(cur);
  assign vt     = v_total(cur);
  assign h_last = (13'(hcount) == ht - 13'd1);
  assign v_last = (12'(vcount) == vt - 12'd1);
  assign wrap   = enable_in && h_last && v_last;

  always_comb begin
    h_next = hcount + 1'b1;
    v_next = vcount;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : vcount + 1'b1;
    end
  end

  // (0,0) decodes identically under any legal timing, so using the outgoing
  // timing on the wrap edge is safe.
  assign dec_next = decode(cur, h_next, v_next);

`ifdef XVGA_RUNTIME_CFG_EN
  xvga_timing_t act, pend;
  logic         pend_vld, err, take, offer_ok;

  assign take     = cfg.cfg_valid_in && !pend_vld;
  assign offer_ok = timing_ok(cfg.cfg_in);

  always_ff @(posedge vclock_in) begin
    if (!rst_n_in) begin
      act      <= PARAM_TIMING;
      pend_vld <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= take && !offer_ok;
      if (wrap && pend_vld) begin
        act      <= pend;
        pend_vld <= 1'b0;
      end
      if (take && offer_ok) pend_vld <= 1'b1;
    end
  end

  always_ff @(posedge vclock_in) begin
    if (take) pend <= cfg.cfg_in;
  end

  assign cur               = act;
  assign cfg.cfg_ready_out = !pend_vld;
  assign cfg.cfg_err_out   = err;
`else
  logic unused_cfg;
  assign unused_cfg        = ^{cfg.cfg_valid_in, cfg.cfg_in};
  assign cur               = PARAM_TIMING;
  assign cfg.cfg_ready_out = 1'b0;
  assign cfg.cfg_err_out   = 1'b0;
`endif

  // Stage p0: counts and their registered decode.
  always_ff @(posedge vclock_in) begin
    if (!rst_n_in) begin
      hcount         <= '0;
      vcount         <= '0;
      frame_count    <= '0;
      hsync_p0       <= ~HSYNC_POL;
      vsync_p0       <= ~VSYNC_POL;
      blank_p0       <= 1'b0;
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
    end else begin
      line_start_p0  <= 1'b0;
      frame_start_p0 <= 1'b0;
      if (enable_in) begin
        hcount         <= h_next;
        vcount         <= v_next;
        hsync_p0       <= dec_next[2] ? HSYNC_POL : ~HSYNC_POL;
        vsync_p0       <= dec_next[1] ? VSYNC_POL : ~VSYNC_POL;
        blank_p0       <= dec_next[0];
        line_start_p0  <= h_last;
        frame_start_p0 <= h_last && v_last;
      end
      if (wrap) frame_count <= frame_count + 16'd1;
    end
  end

  // Stage p1..pN: alignment delay for sync, blank and strobes.
  logic [4:0] dly_in, dly_out;
  assign dly_in = {hsync_p0, vsync_p0, blank_p0, line_start_p0, frame_start_p0};

  xvga_delay_line #(
    .WIDTH   (5),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~HSYNC_POL, ~VSYNC_POL, 3'b000})
  ) u_dly (
    .clk   (vclock_in),
    .rst_n (rst_n_in),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign {hsync_out, vsync_out, blank_out, line_start_out, frame_start_out} = dly_out;
  assign hcount_out      = hcount;
  assign vcount_out      = vcount;
  assign frame_count_out = frame_count;

endmodule

// File: tb/tb_xvga_timing.sv
// tb_xvga_timing: directed and randomized stimulus on two small-raster instances
// (no delay / delay 3 with inverted hsync) checked every clock against a raster model.
module tb_xvga_timing;
  import xvga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int FRAME = (HA + HF + HS + HB) * (VA + VF + VS + VB);
  localparam bit A_HPOL = 1'b0, A_VPOL = 1'b0;
  localparam bit B_HPOL = 1'b1, B_VPOL = 1'b0;
  localparam int B_DELAY = 3;
`ifdef XVGA_RUNTIME_CFG_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, en, cv;
  xvga_timing_t ci;

  logic [10:0] a_hcount, b_hcount;
  logic [9:0]  a_vcount, b_vcount;
  logic        a_hsync, a_vsync, a_blank, a_ls, a_fs;
  logic        b_hsync, b_vsync, b_blank, b_ls, b_fs;
  logic [15:0] a_fc, b_fc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fs     = 0;

  always #5 clk = ~clk;

  xvga_timing_if if_a ();
  xvga_timing_if if_b ();
  assign if_a.cfg_valid_in = cv;
  assign if_a.cfg_in       = ci;
  assign if_b.cfg_valid_in = cv;
  assign if_b.cfg_in       = ci;

  xvga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(A_HPOL), .VSYNC_POL(A_VPOL), .PIPE_DELAY(0)
  ) dut_a (
    .vclock_in(clk), .rst_n_in(rst_n), .enable_in(en), .cfg(if_a.slave),
    .hcount_out(a_hcount), .vcount_out(a_vcount), .hsync_out(a_hsync),
    .vsync_out(a_vsync), .blank_out(a_blank), .line_start_out(a_ls),
    .frame_start_out(a_fs), .frame_count_out(a_fc)
  );

  xvga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(B_HPOL), .VSYNC_POL(B_VPOL), .PIPE_DELAY(B_DELAY)
  ) dut_b (
    .vclock_in(clk), .rst_n_in(rst_n), .enable_in(en), .cfg(if_b.slave),
    .hcount_out(b_hcount), .vcount_out(b_vcount), .hsync_out(b_hsync),
    .vsync_out(b_vsync), .blank_out(b_blank), .line_start_out(b_ls),
    .frame_start_out(b_fs), .frame_count_out(b_fc)
  );

  // Reference raster state.
  xvga_timing_t m_act, m_pend;
  int           m_h, m_v, m_fc;
  bit           m_pv, m_err;
  bit [4:0]     hist [4];   // {hs_act, vs_act, blank, line_start, frame_start}, [k] = k clocks old

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic xvga_timing_t mk(int ha, int hf, int hs, int hb,
                                      int va, int vf, int vs, int vb);
    xvga_timing_t t;
    t.h_active = 11'(ha); t.h_fp = 11'(hf); t.h_sync = 11'(hs); t.h_bp = 11'(hb);
    t.v_active = 10'(va); t.v_fp = 10'(vf); t.v_sync = 10'(vs); t.v_bp = 10'(vb);
    return t;
  endfunction

  function automatic int tot_h(xvga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int tot_v(xvga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  function automatic bit legal(xvga_timing_t t);
    if (t.h_active == 0 || t.h_fp == 0 || t.h_sync == 0 || t.h_bp == 0) return 1'b0;
    if (t.v_active == 0 || t.v_fp == 0 || t.v_sync == 0 || t.v_bp == 0) return 1'b0;
    return (tot_h(t) <= 2048) && (tot_v(t) <= 1024);
  endfunction

  function automatic bit [2:0] model_dec(xvga_timing_t t, int h, int v);
    int hs0, vs0;
    bit hs, vs, bl;
    hs0 = int'(t.h_active) + int'(t.h_fp);
    vs0 = int'(t.v_active) + int'(t.v_fp);
    hs  = (h >= hs0) && (h < hs0 + int'(t.h_sync));
    vs  = (v >= vs0) && (v < vs0 + int'(t.v_sync));
    bl  = (h >= int'(t.h_active)) || (v >= int'(t.v_active));
    return {hs, vs, bl};
  endfunction

  function automatic bit lvl(bit act, bit pol);
    return act ? pol : !pol;
  endfunction

  task automatic model_edge();
    int           ht, vt;
    bit           wrap, old_pv;
    xvga_timing_t old_pend;
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_fc = 0; m_act = mk(HA, HF, HS, HB, VA, VF, VS, VB);
      m_pv = 1'b0; m_err = 1'b0;
      for (int k = 0; k < 4; k++) hist[k] = '0;
      return;
    end
    ht    = tot_h(m_act);
    vt    = tot_v(m_act);
    wrap  = en && (m_h == ht - 1) && (m_v == vt - 1);
    m_err = 1'b0;
    if (en) begin
      m_h = (m_h + 1) % ht;
      if (m_h == 0) m_v = (m_v + 1) % vt;
      if (wrap) m_fc = (m_fc + 1) % 65536;
    end
    if (RT) begin
      old_pv   = m_pv;
      old_pend = m_pend;
      if (wrap && old_pv) begin
        m_act = old_pend;
        m_pv  = 1'b0;
      end
      if (cv && !old_pv) begin
        if (legal(ci)) begin
          m_pend = ci;
          m_pv   = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = {model_dec(m_act, m_h, m_v), en && (m_h == 0), en && (m_h == 0) && (m_v == 0)};
  endtask

  task automatic compare_all();
    bit [4:0] ea, eb;
    bit       rdy;
    ea  = hist[0];
    eb  = hist[B_DELAY];
    rdy = RT && !m_pv;
    check("a_hcount", a_hcount, m_h);
    check("a_vcount", a_vcount, m_v);
    check("a_frame_count", a_fc, m_fc);
    check("a_hsync", a_hsync, lvl(ea[4], A_HPOL));
    check("a_vsync", a_vsync, lvl(ea[3], A_VPOL));
    check("a_blank", a_blank, ea[2]);
    check("a_line_start", a_ls, ea[1]);
    check("a_frame_start", a_fs, ea[0]);
    check("a_cfg_ready", if_a.cfg_ready_out, rdy);
    check("a_cfg_err", if_a.cfg_err_out, m_err);
    check("b_hcount", b_hcount, m_h);
    check("b_vcount", b_vcount, m_v);
    check("b_frame_count", b_fc, m_fc);
    check("b_hsync", b_hsync, lvl(eb[4], B_HPOL));
    check("b_vsync", b_vsync, lvl(eb[3], B_VPOL));
    check("b_blank", b_blank, eb[2]);
    check("b_line_start", b_ls, eb[1]);
    check("b_frame_start", b_fs, eb[0]);
    check("b_cfg_ready", if_b.cfg_ready_out, rdy);
    check("b_cfg_err", if_b.cfg_err_out, m_err);
    if (a_fs === 1'b1) n_fs++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic offer(input xvga_timing_t t);
    cv = 1'b1;
    ci = t;
    step();
    cv = 1'b0;
  endtask

  task automatic rand_cfg(output xvga_timing_t t);
    int kind;
    kind = int'($urandom_range(0, 11));
    t = mk(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
           int'($urandom_range(1, 4)),  int'($urandom_range(1, 4)),
           int'($urandom_range(1, 6)),  int'($urandom_range(1, 3)),
           int'($urandom_range(1, 3)),  int'($urandom_range(1, 3)));
    case (kind)
      0: t.h_active = '0;
      1: t.h_sync   = '0;
      2: t.v_bp     = '0;
      3: t.h_active = 11'd2047;
      4: t.v_active = 10'd1023;
      5: t.v_fp     = '0;
      default: ;
    endcase
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    cv    = 1'b0;
    ci    = mk(HA, HF, HS, HB, VA, VF, VS, VB);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    en = 1'b1;
    repeat (2 * FRAME + 10) step();

    for (int i = 0; i < 300; i++) begin
      en = (i % 2 == 0);
      step();
    end
    en = 1'b1;

    for (int i = 0; i < 4 * FRAME && m_v != 3; i++) step();
    offer(mk(10, 2, 3, 4, 5, 1, 2, 3));
    repeat (2 * FRAME) step();

    offer(mk(10, 2, 0, 4, 5, 1, 2, 3));
    repeat (30) step();

    repeat (57) step();
    pulse_reset();
    repeat (5) step();

    offer(mk(2045, 1, 1, 1, 1, 1, 1, 1));
    repeat (3) step();
    pulse_reset();
    offer(mk(2046, 1, 1, 1, 1, 1, 1, 1));
    repeat (3) step();
    offer(mk(1, 1, 1, 1, 1021, 1, 1, 1));
    repeat (3) step();
    pulse_reset();
    offer(mk(1, 1, 1, 1, 1022, 1, 1, 1));
    repeat (3) step();

    for (int i = 0; i < 15000; i++) begin
      rst_n = ($urandom_range(0, 2999) != 0);
      en    = ($urandom_range(0, 3) != 0) || (i % 4000 < 800);
      cv    = ($urandom_range(0, 19) == 0);
      rand_cfg(ci);
      step();
    end

    check("frames_seen", n_fs != 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
